// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request and loads the
// IF/ID register. It handles stalls, downstream redirects (including during a miss) and halt.
package fetch_pkg;
  typedef enum logic [2:0] {
    NO_STALL   = 3'd0,
    IFID_STALL = 3'd1,
    IDEX_STALL = 3'd2,
    FULL_STALL = 3'd3
  } pipe_stall_t;

  typedef struct packed {
    logic [31:0] imemload;
    logic [31:0] pc_plus;
  } ifid_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic [2:0]  stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output ifid_t       ifid,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DROP   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        ren;
  logic        hold;

  // Any non-zero stall code, including undefined ones, freezes the stage.
  assign hold     = (stall != 3'(NO_STALL));
  assign imemaddr = pc;
  assign imemREN  = ren;

  // Fetch state machine, PC and IF/ID register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      pc         <= PC0;
      pend_pc    <= 32'h0000_0000;
      ifid       <= '0;
      ifid_valid <= 1'b0;
      ren        <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state      <= HALTED;
            ren        <= 1'b0;
            ifid       <= '0;
            ifid_valid <= 1'b0;
          end else if (redirect) begin
            ifid       <= '0;
            ifid_valid <= 1'b0;
            if (ihit) begin
              pc <= redirect_pc;
            end else begin
              // The miss is still in flight; wait for it before re-steering.
              pend_pc <= redirect_pc;
              state   <= DROP;
            end
          end else if (hold) begin
            ifid       <= ifid;
            ifid_valid <= ifid_valid;
          end else if (ihit) begin
            ifid.imemload <= imemload;
            ifid.pc_plus  <= pc + 32'd4;
            ifid_valid    <= 1'b1;
            pc            <= pc + 32'd4;
          end else begin
            ifid       <= '0;
            ifid_valid <= 1'b0;
          end
        end
        DROP: begin
          ifid       <= '0;
          ifid_valid <= 1'b0;
          if (halt) begin
            state <= HALTED;
            ren   <= 1'b0;
          end else if (ihit) begin
            // Stale data is discarded; a concurrent redirect is the newest target.
            pc    <= redirect ? redirect_pc : pend_pc;
            state <= RUN;
          end else if (redirect) begin
            pend_pc <= redirect_pc;
          end else begin
            pend_pc <= pend_pc;
          end
        end
        HALTED: begin
          ren        <= 1'b0;
          ifid       <= '0;
          ifid_valid <= 1'b0;
        end
        default: begin
          state      <= HALTED;
          ren        <= 1'b0;
          ifid       <= '0;
          ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed test-plan sequences plus random
// stimulus, checked against a cycle-level behavioural model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] P0 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemren;
  logic [31:0] imemaddr;
  logic [2:0]  stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  ifid_t       ifid;
  logic        ifid_valid;

  fetch_stage #(.PC0(P0)) dut (
    .CLK(clk), .nRST(nrst), .ihit(ihit), .imemload(imemload),
    .imemREN(imemren), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ifid(ifid), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ren;
    logic [31:0] load;
    logic [31:0] pcplus;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: 0 = fetching, 1 = waiting out a stale miss, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_pend, m_load, m_pcplus;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_load = 32'h0; m_pcplus = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model(input logic rst, input logic h, input logic [31:0] ld,
                       input logic [2:0] st, input logic rd, input logic [31:0] rpc,
                       input logic hl);
    if (rst) begin
      m_mode = 0; m_pc = P0; m_pend = 32'h0; bubble();
    end else if (m_mode == 2) begin
      bubble();
    end else if (m_mode == 1) begin
      bubble();
      if (hl) m_mode = 2;
      else if (h) begin m_pc = rd ? rpc : m_pend; m_mode = 0; end
      else if (rd) m_pend = rpc;
    end else if (hl) begin
      m_mode = 2; bubble();
    end else if (rd) begin
      bubble();
      if (h) m_pc = rpc;
      else begin m_pend = rpc; m_mode = 1; end
    end else if (st != 3'd0) begin
      // everything holds
    end else if (h) begin
      m_load = ld; m_pcplus = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end else begin
      bubble();
    end
  endtask

  // One cycle: drive, predict, then return just after the following negedge.
  task automatic step(input logic rst, input logic h, input logic [31:0] ld,
                      input logic [2:0] st, input logic rd, input logic [31:0] rpc,
                      input logic hl);
    exp_t e;
    nrst = ~rst; ihit = h; imemload = ld; stall = st;
    redirect = rd; redirect_pc = rpc; halt = hl;
    model(rst, h, ld, st, rd, rpc, hl);
    e.addr = m_pc; e.ren = (m_mode != 2); e.load = m_load;
    e.pcplus = m_pcplus; e.valid = m_valid;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic h, input logic [31:0] ld);
    step(1'b0, h, ld, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] t);
    step(1'b0, 1'b1, 32'h0, 3'd0, 1'b1, t, 1'b0);
  endtask

  // Monitor: every negedge the DUT outputs are compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("imemaddr", imemaddr, e.addr);
        chk("imemREN", {31'd0, imemren}, {31'd0, e.ren});
        chk("imemload", ifid.imemload, e.load);
        chk("pc_plus", ifid.pc_plus, e.pcplus);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
      end
    end
  end

  initial begin
    logic [2:0] st;
    // Reset with a hit present, then release.
    step(1'b1, 1'b1, 32'hAAAA_0001, 3'd0, 1'b0, 32'h0, 1'b0);
    chk("tp_reset_addr", imemaddr, 32'h100);
    step(1'b1, 1'b1, 32'hAAAA_0001, 3'd0, 1'b0, 32'h0, 1'b0);
    go(1'b1, 32'hAAAA_0001);
    chk("tp_first_load", ifid.imemload, 32'hAAAA_0001);
    chk("tp_first_pcplus", ifid.pc_plus, 32'h104);
    chk("tp_first_addr", imemaddr, 32'h104);
    // Misses then a hit at 0x10.
    jump(32'h10);
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 32'h0);
      chk("tp_miss_addr", imemaddr, 32'h10);
    end
    go(1'b1, 32'h1234_5678);
    chk("tp_miss_pcplus", ifid.pc_plus, 32'h14);
    // Stall with hits at 0x20.
    jump(32'h20);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h5555_0000, 3'd2, 1'b0, 32'h0, 1'b0);
      chk("tp_stall_addr", imemaddr, 32'h20);
    end
    go(1'b1, 32'h5555_0000);
    chk("tp_stall_release", imemaddr, 32'h24);
    // Redirect with hit.
    jump(32'h30);
    jump(32'h400);
    chk("tp_redir_addr", imemaddr, 32'h400);
    chk("tp_redir_valid", {31'd0, ifid_valid}, 32'd0);
    // Redirects during a miss.
    jump(32'h40);
    step(1'b0, 1'b0, 32'h0, 3'd0, 1'b1, 32'h500, 1'b0);
    chk("tp_drop_addr0", imemaddr, 32'h40);
    go(1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 3'd1, 1'b1, 32'h600, 1'b0);
    chk("tp_drop_addr1", imemaddr, 32'h40);
    go(1'b1, 32'hDEAD_BEEF);
    chk("tp_drop_target", imemaddr, 32'h600);
    chk("tp_drop_discard", {31'd0, ifid_valid}, 32'd0);
    // Wraparound then halt.
    jump(32'hFFFF_FFFC);
    go(1'b1, 32'h0BAD_F00D);
    chk("tp_wrap_pcplus", ifid.pc_plus, 32'h0);
    chk("tp_wrap_addr", imemaddr, 32'h0);
    step(1'b0, 1'b1, 32'h1, 3'd0, 1'b1, 32'h700, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h2, 3'd0, 1'b1, 32'h800, 1'b0);
      chk("tp_halt_ren", {31'd0, imemren}, 32'd0);
    end
    step(1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
    chk("tp_halt_reset", imemaddr, P0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom(),
           st,
           ($urandom_range(0, 7) == 0),
           $urandom(),
           ($urandom_range(0, 59) == 0));
    end
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
